// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle for the shared memory port: fetch side, data side and unified memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;

  // master: the arbiter itself
  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_rdata, if_valid, if_stall,
    output dm_rdata, dm_valid, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output err
  );

  // slave: pipeline requesters and memory
  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_rdata, if_valid, if_stall,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access,
// with fetch anti-starvation and a watchdog abort on the memory handshake.
//
// state | meaning
// IDLE  | no transaction; arbitrate between if_req and dm_req
// BUSY  | mem_req held, waiting for mem_ack or watchdog expiry
// RESP  | owner's valid (and err on abort) pulse; back to IDLE
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [7:0]      TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t            state_q,   state_nxt;
  owner_t            owner_q,   owner_nxt;
  logic [SC_W-1:0]   starve_q,  starve_nxt;
  logic [7:0]        to_cnt_q,  to_cnt_nxt;

  logic              mem_req_q,   mem_req_nxt;
  logic              mem_we_q,    mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_nxt;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_nxt;
  logic              if_valid_q,  if_valid_nxt;
  logic              dm_valid_q,  dm_valid_nxt;
  logic              err_q,       err_nxt;

  logic              fetch_win;

  // fetch wins when uncontested or once data has starved it STARVE_MAX times
  assign fetch_win = bus.if_req & (~bus.dm_req | (starve_q == STARVE_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      to_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      owner_q     <= owner_nxt;
      starve_q    <= starve_nxt;
      to_cnt_q    <= to_cnt_nxt;
      mem_req_q   <= mem_req_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      if_rdata_q  <= if_rdata_nxt;
      dm_rdata_q  <= dm_rdata_nxt;
      if_valid_q  <= if_valid_nxt;
      dm_valid_q  <= dm_valid_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    owner_nxt     = owner_q;
    starve_nxt    = starve_q;
    to_cnt_nxt    = to_cnt_q;
    mem_req_nxt   = mem_req_q;
    mem_we_nxt    = mem_we_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    if_rdata_nxt  = if_rdata_q;
    dm_rdata_nxt  = dm_rdata_q;
    if_valid_nxt  = 1'b0;
    dm_valid_nxt  = 1'b0;
    err_nxt       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          state_nxt   = S_BUSY;
          mem_req_nxt = 1'b1;
          to_cnt_nxt  = '0;
          if (fetch_win) begin
            owner_nxt     = OWN_IF;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.if_addr;
            mem_wdata_nxt = '0;
            starve_nxt    = '0;
          end else begin
            owner_nxt     = OWN_DM;
            mem_we_nxt    = bus.dm_we;
            mem_addr_nxt  = bus.dm_addr;
            mem_wdata_nxt = bus.dm_wdata;
            if (bus.if_req && (starve_q != STARVE_LIM))
              starve_nxt = starve_q + SC_W'(1);
          end
        end
      end

      S_BUSY: begin
        if (bus.mem_ack) begin
          state_nxt   = S_RESP;
          mem_req_nxt = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rdata_nxt = bus.mem_rdata;
            if_valid_nxt = 1'b1;
          end else begin
            // a store completion leaves the load data register alone
            if (!mem_we_q)
              dm_rdata_nxt = bus.mem_rdata;
            dm_valid_nxt = 1'b1;
          end
        end else begin
          to_cnt_nxt = to_cnt_q + 8'd1;
          if (to_cnt_q == TO_LAST) begin
            state_nxt   = S_RESP;
            mem_req_nxt = 1'b0;
            err_nxt     = 1'b1;
            if (owner_q == OWN_IF) begin
              if_rdata_nxt = '1;
              if_valid_nxt = 1'b1;
            end else begin
              dm_rdata_nxt = '1;
              dm_valid_nxt = 1'b1;
            end
          end
        end
      end

      S_RESP: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end

      default: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

endmodule
